mram_burst_ctrl: RTL and testbench

- Parametrised next-generation MRAM access sequencer; replaces the fixed-count 16-bit/20-bit controller.
- Accepts a command through a valid/ready handshake and sequences the serial-in address/data shift registers, the async MRAM strobes and the serial read-out shifter.
- Supports configurable widths and timing, single- or multi-beat bursts with address auto-increment, and explicit busy/done status.
- Sits between the host-side command logic and the existing STP/PTS datapath modules.

---
 rtl/mram_ctrl_pkg.sv | 60 ++++++
 rtl/mram_burst_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mram_burst_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mram_ctrl_pkg.sv
// Shared types and helpers for the MRAM burst sequencer: state encoding,
// byte-enable codes and the bundle of active-low MRAM strobes.
package mram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_RD_STROBE,
    ST_RD_SHIFT,
    ST_RECOVER
  } state_t;

  // Byte-enable encodings: bit0 = lower byte, bit1 = upper byte.
  localparam logic [1:0] BE_NOP  = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_FULL = 2'b11;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } strobe_t;

  // Every strobe deasserted; the only legal value outside the strobe phases.
  localparam strobe_t STROBE_IDLE = 5'b11111;

  // Write strobes: we_n low, byte lanes from be, ce_n chosen by the caller
  // (high during setup, low during the write pulse).
  function automatic strobe_t wr_strobe(input logic [1:0] be, input logic ce_n);
    strobe_t s;
    s.ce_n = ce_n;
    s.we_n = 1'b0;
    s.oe_n = 1'b1;
    s.lb_n = ~be[0];
    s.ub_n = ~be[1];
    return s;
  endfunction

  // Read strobes: chip and output enables low, we_n held high so it can
  // never overlap oe_n.
  function automatic strobe_t rd_strobe(input logic [1:0] be);
    strobe_t s;
    s.ce_n = 1'b0;
    s.we_n = 1'b1;
    s.oe_n = 1'b0;
    s.lb_n = ~be[0];
    s.ub_n = ~be[1];
    return s;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mram_burst_ctrl.sv
// MRAM access sequencer. Accepts one command over a valid/ready handshake and
// walks it through address/data serial shift-in, the async MRAM strobe
// phases and serial read-out, repeating per beat with address auto-increment.
// All outputs are registered; each cycle the sequencer computes the values
// that the following cycle must present.
// Parameter constraints: DATA_W even and <= ADDR_W; SETUP_CYC, WR_CYC and
// RD_CYC all >= 1.
module mram_burst_ctrl
  import mram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 4,
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 1,
  parameter int RD_CYC    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [1:0]       cmd_be,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             addr_en,
  output logic             addr_inc,
  output logic             data_en,
  output logic             send_data,
  output logic             load,
  output logic             data_out_en,
  output logic             ce_n,
  output logic             we_n,
  output logic             oe_n,
  output logic             lb_n,
  output logic             ub_n
);

  // One phase counter covers every timed phase, so it is sized for the longest.
  localparam int PH_MAX = imax(imax(imax(ADDR_W, DATA_W), imax(SETUP_CYC, WR_CYC)), RD_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Counter holds "cycles remaining minus one"; a phase ends when it reads 0.
  localparam logic [PH_W-1:0] PH_ADDR_LAST  = PH_W'(ADDR_W - 1);
  localparam logic [PH_W-1:0] PH_DATA_LAST  = PH_W'(DATA_W - 1);
  localparam logic [PH_W-1:0] PH_HALF_LAST  = PH_W'(DATA_W / 2 - 1);
  localparam logic [PH_W-1:0] PH_SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] PH_WR_LAST    = PH_W'(WR_CYC - 1);
  localparam logic [PH_W-1:0] PH_RD_LAST    = PH_W'(RD_CYC - 1);
  localparam logic [PH_W-1:0] PH_ONE        = PH_W'(1);
  // On beat 0 data shifts during the first DATA_W of the ADDR_W address
  // cycles, i.e. while more than ADDR_W-DATA_W cycles remain after this one.
  localparam logic [PH_W-1:0] PH_DATA_GAP   = PH_W'(ADDR_W - DATA_W);

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [LEN_W-1:0] beat;
  logic             lat_write;
  logic [1:0]       lat_be;
  logic [LEN_W-1:0] lat_len;
  strobe_t          strb;

  logic             last_beat;
  logic [PH_W-1:0]  shift_gap;
  logic [PH_W-1:0]  rd_shift_last;

  // A nop is always its own last beat so it never increments the address.
  assign last_beat     = (lat_be == BE_NOP) || (beat == lat_len);
  // Later write beats shift data for the whole SHIFT phase.
  assign shift_gap     = (beat == '0) ? PH_DATA_GAP : '0;
  // Single-byte reads only shift out half a word.
  assign rd_shift_last = ((lat_be == BE_LO) || (lat_be == BE_HI)) ? PH_HALF_LAST : PH_DATA_LAST;

  assign ce_n = strb.ce_n;
  assign we_n = strb.we_n;
  assign oe_n = strb.oe_n;
  assign lb_n = strb.lb_n;
  assign ub_n = strb.ub_n;

  // Sequencer: state, phase/beat counters, latched command and all output registers.
  // NOTE: every register here uses <=, so each branch reads the pre-edge
  // values of state/phase/beat regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      phase       <= '0;
      beat        <= '0;
      lat_write   <= 1'b0;
      lat_be      <= BE_NOP;
      lat_len     <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_en     <= 1'b0;
      addr_inc    <= 1'b0;
      data_en     <= 1'b0;
      send_data   <= 1'b0;
      load        <= 1'b0;
      data_out_en <= 1'b0;
      strb        <= STROBE_IDLE;
    end else begin
      // Phase-local outputs fall back to idle unless re-asserted below.
      done        <= 1'b0;
      addr_inc    <= 1'b0;
      addr_en     <= 1'b0;
      data_en     <= 1'b0;
      send_data   <= 1'b0;
      load        <= 1'b0;
      data_out_en <= 1'b0;
      strb        <= STROBE_IDLE;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_be    <= cmd_be;
            lat_len   <= cmd_len;
            beat      <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_be == BE_NOP) begin
              state <= ST_RECOVER;
              phase <= '0;
              done  <= 1'b1;
            end else begin
              state   <= ST_SHIFT;
              phase   <= PH_ADDR_LAST;
              addr_en <= 1'b1;
              data_en <= cmd_write;
            end
          end
        end

        ST_SHIFT: begin
          if (phase != '0) begin
            phase   <= phase - 1'b1;
            addr_en <= (beat == '0);
            data_en <= lat_write && (phase > shift_gap);
          end else if (lat_write) begin
            state <= ST_WR_SETUP;
            phase <= PH_SETUP_LAST;
            strb  <= wr_strobe(lat_be, 1'b1);
          end else begin
            state     <= ST_RD_STROBE;
            phase     <= PH_RD_LAST;
            strb      <= rd_strobe(lat_be);
            send_data <= 1'b1;
            load      <= (PH_RD_LAST == '0);
          end
        end

        ST_WR_SETUP: begin
          if (phase != '0) begin
            phase <= phase - 1'b1;
            strb  <= wr_strobe(lat_be, 1'b1);
          end else begin
            state     <= ST_WR_STROBE;
            phase     <= PH_WR_LAST;
            strb      <= wr_strobe(lat_be, 1'b0);
            send_data <= 1'b1;
          end
        end

        ST_WR_STROBE: begin
          if (phase != '0) begin
            phase     <= phase - 1'b1;
            strb      <= wr_strobe(lat_be, 1'b0);
            send_data <= 1'b1;
          end else begin
            state    <= ST_RECOVER;
            done     <= last_beat;
            addr_inc <= !last_beat;
          end
        end

        ST_RD_STROBE: begin
          if (phase != '0) begin
            phase     <= phase - 1'b1;
            strb      <= rd_strobe(lat_be);
            send_data <= 1'b1;
            load      <= (phase == PH_ONE);
          end else begin
            state       <= ST_RD_SHIFT;
            phase       <= rd_shift_last;
            data_out_en <= 1'b1;
          end
        end

        ST_RD_SHIFT: begin
          if (phase != '0) begin
            phase       <= phase - 1'b1;
            data_out_en <= 1'b1;
          end else begin
            state    <= ST_RECOVER;
            done     <= last_beat;
            addr_inc <= !last_beat;
          end
        end

        ST_RECOVER: begin
          if (last_beat) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            beat <= beat + 1'b1;
            if (lat_write) begin
              // Address is already in place; only the next data word shifts.
              state   <= ST_SHIFT;
              phase   <= PH_DATA_LAST;
              data_en <= 1'b1;
            end else begin
              // Reads have nothing to shift in after beat 0.
              state     <= ST_RD_STROBE;
              phase     <= PH_RD_LAST;
              strb      <= rd_strobe(lat_be);
              send_data <= 1'b1;
              load      <= (PH_RD_LAST == '0);
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          phase     <= '0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mram_burst_ctrl.sv
// Directed bench for mram_burst_ctrl at default parameters. Each command is
// issued in cycle 0 and the outputs of cycles 0..n are recorded into
// per-signal bit vectors (bit k = cycle k), then compared with hand-built
// expected vectors.
module tb_mram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [1:0] cmd_be = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       busy, done, addr_en, addr_inc, data_en, send_data, load, data_out_en;
  logic       ce_n, we_n, oe_n, lb_n, ub_n;

  int checks = 0;
  int failures = 0;

  // Traces: strobe traces record "strobe is low" so expected masks read naturally.
  logic [127:0] t_addr_en, t_data_en, t_addr_inc, t_done, t_load, t_dout, t_send;
  logic [127:0] t_ce, t_we, t_oe, t_lb, t_ub, t_ready, t_busy;

  always #5 clk = ~clk;

  mram_burst_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_be      (cmd_be),
    .cmd_len     (cmd_len),
    .busy        (busy),
    .done        (done),
    .addr_en     (addr_en),
    .addr_inc    (addr_inc),
    .data_en     (data_en),
    .send_data   (send_data),
    .load        (load),
    .data_out_en (data_out_en),
    .ce_n        (ce_n),
    .we_n        (we_n),
    .oe_n        (oe_n),
    .lb_n        (lb_n),
    .ub_n        (ub_n)
  );

  function automatic logic [127:0] mask(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] at(input int k);
    return mask(k, k);
  endfunction

  // Issue a command in cycle 0 and record cycles 0..n. rst_at>0 pulls rst low
  // for the edge ending that cycle; hold_until>0 keeps cmd_valid high with
  // scrambled fields for cycles below it.
  task automatic run_cmd(input logic w, input logic [1:0] b, input logic [3:0] l,
                         input int n, input int rst_at, input int hold_until);
    t_addr_en = '0; t_data_en = '0; t_addr_inc = '0; t_done = '0; t_load = '0;
    t_dout = '0; t_send = '0; t_ce = '0; t_we = '0; t_oe = '0; t_lb = '0; t_ub = '0;
    t_ready = '0; t_busy = '0;
    @(negedge clk);
    t_ready[0] = cmd_ready;
    t_busy[0]  = busy;
    cmd_valid = 1'b1; cmd_write = w; cmd_be = b; cmd_len = l;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      t_addr_en[k]  = addr_en;
      t_data_en[k]  = data_en;
      t_addr_inc[k] = addr_inc;
      t_done[k]     = done;
      t_load[k]     = load;
      t_dout[k]     = data_out_en;
      t_send[k]     = send_data;
      t_ce[k]       = (ce_n === 1'b0);
      t_we[k]       = (we_n === 1'b0);
      t_oe[k]       = (oe_n === 1'b0);
      t_lb[k]       = (lb_n === 1'b0);
      t_ub[k]       = (ub_n === 1'b0);
      t_ready[k]    = cmd_ready;
      t_busy[k]     = busy;
      if (k < hold_until) begin
        cmd_valid = 1'b1;
        cmd_write = 1'(k & 1);
        cmd_be    = 2'(k);
        cmd_len   = 4'(k + 3);
      end else begin
        cmd_valid = 1'b0;
      end
      if (rst_at != 0 && k == rst_at) rst = 1'b0;
      else if (rst_at != 0 && k == rst_at + 1) rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_be = 2'b11;
    repeat (3) @(negedge clk);
    checks++; if ({ce_n, we_n, oe_n, lb_n, ub_n} !== 5'b11111) begin failures++; $display("FAIL rst_strobes got=%b exp=11111", {ce_n, we_n, oe_n, lb_n, ub_n}); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    checks++; if ({busy, done, addr_en, addr_inc, data_en, send_data, load, data_out_en} !== 8'h00)
      begin failures++; $display("FAIL rst_outputs got=%b exp=00000000", {busy, done, addr_en, addr_inc, data_en, send_data, load, data_out_en}); end
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL rst_release got=%b exp=10", {cmd_ready, busy}); end
  endtask

  task automatic test_write_single();
    run_cmd(1'b1, 2'b11, 4'd0, 25, 0, 0);
    checks++; if (t_addr_en !== mask(1, 20)) begin failures++; $display("FAIL wr_addr_en got=%h exp=%h", t_addr_en, mask(1, 20)); end
    checks++; if (t_data_en !== mask(1, 16)) begin failures++; $display("FAIL wr_data_en got=%h exp=%h", t_data_en, mask(1, 16)); end
    checks++; if (t_we !== mask(21, 22)) begin failures++; $display("FAIL wr_we got=%h exp=%h", t_we, mask(21, 22)); end
    checks++; if ((t_lb !== mask(21, 22)) || (t_ub !== mask(21, 22))) begin failures++; $display("FAIL wr_lb_ub got=%h/%h exp=%h", t_lb, t_ub, mask(21, 22)); end
    checks++; if (t_ce !== at(22)) begin failures++; $display("FAIL wr_ce got=%h exp=%h", t_ce, at(22)); end
    checks++; if (t_oe !== '0) begin failures++; $display("FAIL wr_oe got=%h exp=0", t_oe); end
    checks++; if (t_send !== at(22)) begin failures++; $display("FAIL wr_send got=%h exp=%h", t_send, at(22)); end
    checks++; if (t_done !== at(23)) begin failures++; $display("FAIL wr_done got=%h exp=%h", t_done, at(23)); end
    checks++; if (t_ready !== (at(0) | mask(24, 25))) begin failures++; $display("FAIL wr_ready got=%h exp=%h", t_ready, at(0) | mask(24, 25)); end
    checks++; if (t_busy !== mask(1, 23)) begin failures++; $display("FAIL wr_busy got=%h exp=%h", t_busy, mask(1, 23)); end
    checks++; if ((t_addr_inc | t_load | t_dout) !== '0) begin failures++; $display("FAIL wr_rd_sigs got=%h exp=0", t_addr_inc | t_load | t_dout); end
  endtask

  task automatic test_read_lo(input string tag);
    run_cmd(1'b0, 2'b01, 4'd0, 33, 0, 0);
    checks++; if (t_addr_en !== mask(1, 20)) begin failures++; $display("FAIL %s_addr_en got=%h exp=%h", tag, t_addr_en, mask(1, 20)); end
    checks++; if ((t_data_en | t_we | t_ub | t_addr_inc) !== '0) begin failures++; $display("FAIL %s_idle_sigs got=%h exp=0", tag, t_data_en | t_we | t_ub | t_addr_inc); end
    checks++; if ((t_ce !== mask(21, 22)) || (t_oe !== mask(21, 22))) begin failures++; $display("FAIL %s_ce_oe got=%h/%h exp=%h", tag, t_ce, t_oe, mask(21, 22)); end
    checks++; if (t_lb !== mask(21, 22)) begin failures++; $display("FAIL %s_lb got=%h exp=%h", tag, t_lb, mask(21, 22)); end
    checks++; if (t_send !== mask(21, 22)) begin failures++; $display("FAIL %s_send got=%h exp=%h", tag, t_send, mask(21, 22)); end
    checks++; if (t_load !== at(22)) begin failures++; $display("FAIL %s_load got=%h exp=%h", tag, t_load, at(22)); end
    checks++; if (t_dout !== mask(23, 30)) begin failures++; $display("FAIL %s_dout got=%h exp=%h", tag, t_dout, mask(23, 30)); end
    checks++; if (t_done !== at(31)) begin failures++; $display("FAIL %s_done got=%h exp=%h", tag, t_done, at(31)); end
    checks++; if (t_ready !== (at(0) | mask(32, 33))) begin failures++; $display("FAIL %s_ready got=%h exp=%h", tag, t_ready, at(0) | mask(32, 33)); end
  endtask

  task automatic test_read_full();
    run_cmd(1'b0, 2'b11, 4'd0, 40, 0, 0);
    checks++; if ((t_lb !== mask(21, 22)) || (t_ub !== mask(21, 22))) begin failures++; $display("FAIL rdf_lb_ub got=%h/%h exp=%h", t_lb, t_ub, mask(21, 22)); end
    checks++; if (t_dout !== mask(23, 38)) begin failures++; $display("FAIL rdf_dout got=%h exp=%h", t_dout, mask(23, 38)); end
    checks++; if (t_done !== at(39)) begin failures++; $display("FAIL rdf_done got=%h exp=%h", t_done, at(39)); end
  endtask

  task automatic test_read_burst();
    run_cmd(1'b0, 2'b10, 4'd1, 44, 0, 0);
    checks++; if (t_addr_en !== mask(1, 20)) begin failures++; $display("FAIL rdb_addr_en got=%h exp=%h", t_addr_en, mask(1, 20)); end
    checks++; if (t_ub !== (mask(21, 22) | mask(32, 33))) begin failures++; $display("FAIL rdb_ub got=%h exp=%h", t_ub, mask(21, 22) | mask(32, 33)); end
    checks++; if (t_lb !== '0) begin failures++; $display("FAIL rdb_lb got=%h exp=0", t_lb); end
    checks++; if (t_load !== (at(22) | at(33))) begin failures++; $display("FAIL rdb_load got=%h exp=%h", t_load, at(22) | at(33)); end
    checks++; if (t_dout !== (mask(23, 30) | mask(34, 41))) begin failures++; $display("FAIL rdb_dout got=%h exp=%h", t_dout, mask(23, 30) | mask(34, 41)); end
    checks++; if (t_addr_inc !== at(31)) begin failures++; $display("FAIL rdb_addr_inc got=%h exp=%h", t_addr_inc, at(31)); end
    checks++; if (t_done !== at(42)) begin failures++; $display("FAIL rdb_done got=%h exp=%h", t_done, at(42)); end
    checks++; if (t_ready !== (at(0) | mask(43, 44))) begin failures++; $display("FAIL rdb_ready got=%h exp=%h", t_ready, at(0) | mask(43, 44)); end
  endtask

  task automatic test_write_burst();
    logic [127:0] exp_data, exp_we, exp_ce;
    int falls;
    exp_data = mask(1, 16) | mask(24, 39) | mask(43, 58) | mask(62, 77);
    exp_we   = mask(21, 22) | mask(40, 41) | mask(59, 60) | mask(78, 79);
    exp_ce   = at(22) | at(41) | at(60) | at(79);
    run_cmd(1'b1, 2'b11, 4'd3, 82, 0, 0);
    falls = 0;
    for (int k = 1; k <= 82; k++) if (t_ce[k] && !t_ce[k-1]) falls++;
    checks++; if (t_addr_en !== mask(1, 20)) begin failures++; $display("FAIL wrb_addr_en got=%h exp=%h", t_addr_en, mask(1, 20)); end
    checks++; if (t_data_en !== exp_data) begin failures++; $display("FAIL wrb_data_en got=%h exp=%h", t_data_en, exp_data); end
    checks++; if (t_addr_inc !== (at(23) | at(42) | at(61))) begin failures++; $display("FAIL wrb_addr_inc got=%h exp=%h", t_addr_inc, at(23) | at(42) | at(61)); end
    checks++; if (t_we !== exp_we) begin failures++; $display("FAIL wrb_we got=%h exp=%h", t_we, exp_we); end
    checks++; if (t_ce !== exp_ce) begin failures++; $display("FAIL wrb_ce got=%h exp=%h", t_ce, exp_ce); end
    checks++; if (falls !== 4) begin failures++; $display("FAIL wrb_ce_pulses got=%0d exp=4", falls); end
    checks++; if (t_done !== at(80)) begin failures++; $display("FAIL wrb_done got=%h exp=%h", t_done, at(80)); end
    checks++; if (t_busy !== mask(1, 80)) begin failures++; $display("FAIL wrb_busy got=%h exp=%h", t_busy, mask(1, 80)); end
  endtask

  task automatic test_nop();
    run_cmd(1'b1, 2'b00, 4'd5, 6, 0, 0);
    checks++; if (t_done !== at(1)) begin failures++; $display("FAIL nop_done got=%h exp=%h", t_done, at(1)); end
    checks++; if ((t_ce | t_we | t_oe | t_lb | t_ub) !== '0) begin failures++; $display("FAIL nop_strobes got=%h exp=0", t_ce | t_we | t_oe | t_lb | t_ub); end
    checks++; if ((t_addr_inc | t_addr_en | t_data_en | t_send) !== '0) begin failures++; $display("FAIL nop_shift got=%h exp=0", t_addr_inc | t_addr_en | t_data_en | t_send); end
    checks++; if (t_ready !== (at(0) | mask(2, 6))) begin failures++; $display("FAIL nop_ready got=%h exp=%h", t_ready, at(0) | mask(2, 6)); end
  endtask

  task automatic test_reset_mid();
    // rst low across the edge that ends cycle 22 (WR_STROBE).
    run_cmd(1'b1, 2'b11, 4'd0, 25, 22, 0);
    checks++; if (t_ce !== at(22)) begin failures++; $display("FAIL rstm_ce got=%h exp=%h", t_ce, at(22)); end
    checks++; if ((t_we | t_lb | t_ub) !== mask(21, 22)) begin failures++; $display("FAIL rstm_we got=%h exp=%h", t_we | t_lb | t_ub, mask(21, 22)); end
    checks++; if (t_done !== '0) begin failures++; $display("FAIL rstm_done got=%h exp=0", t_done); end
    checks++; if (t_ready !== (at(0) | mask(23, 25))) begin failures++; $display("FAIL rstm_ready got=%h exp=%h", t_ready, at(0) | mask(23, 25)); end
    checks++; if (t_busy !== mask(1, 22)) begin failures++; $display("FAIL rstm_busy got=%h exp=%h", t_busy, mask(1, 22)); end
    test_read_lo("rstm_rd");
  endtask

  task automatic test_busy_ignore();
    run_cmd(1'b1, 2'b11, 4'd0, 26, 0, 23);
    checks++; if (t_addr_en !== mask(1, 20)) begin failures++; $display("FAIL hold_addr_en got=%h exp=%h", t_addr_en, mask(1, 20)); end
    checks++; if (t_data_en !== mask(1, 16)) begin failures++; $display("FAIL hold_data_en got=%h exp=%h", t_data_en, mask(1, 16)); end
    checks++; if ((t_we & t_lb & t_ub) !== mask(21, 22)) begin failures++; $display("FAIL hold_we got=%h exp=%h", t_we & t_lb & t_ub, mask(21, 22)); end
    checks++; if ((t_ce !== at(22)) || (t_oe !== '0)) begin failures++; $display("FAIL hold_ce_oe got=%h/%h exp=%h/0", t_ce, t_oe, at(22)); end
    checks++; if ((t_done !== at(23)) || (t_addr_inc !== '0)) begin failures++; $display("FAIL hold_done got=%h/%h exp=%h/0", t_done, t_addr_inc, at(23)); end
    checks++; if (t_busy !== mask(1, 23)) begin failures++; $display("FAIL hold_busy got=%h exp=%h", t_busy, mask(1, 23)); end
    checks++; if (t_ready !== (at(0) | mask(24, 26))) begin failures++; $display("FAIL hold_ready got=%h exp=%h", t_ready, at(0) | mask(24, 26)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_single();
    test_read_lo("rd");
    test_read_full();
    test_read_burst();
    test_write_burst();
    test_nop();
    test_reset_mid();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
